// File: rtl/rtc_seq_writer.sv
`default_nettype none
// ============================================================================
// Module   : rtc_seq_writer
// Brief    : Write sequencer for the RTC address/data bus. Snapshots a vector
//            of time/date fields on start, presents address then value for
//            each enabled field, and finishes with a transfer command.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_seq_writer #(
    parameter int                    DATA_W       = 8,
    parameter int                    N_FIELDS     = 6,
    parameter logic [N_FIELDS-1:0]   TIMER_MASK   = 6'b000111,
    parameter logic [DATA_W-1:0]     CMD_ADDR_CLK = 8'hF1,
    parameter logic [DATA_W-1:0]     CMD_ADDR_TMR = 8'hF2,
    parameter logic [DATA_W-1:0]     CMD_DATA     = 8'h01,
    localparam int                   IDX_W        = $clog2(N_FIELDS + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         mode,
    input  logic [N_FIELDS*DATA_W-1:0]   addr_vec,
    input  logic [N_FIELDS*DATA_W-1:0]   data_vec,
    input  logic                         addr_phase,
    input  logic                         data_phase,
    input  logic                         advance,
    input  logic                         abort,
    output logic [DATA_W-1:0]            bus_out,
    output logic                         wr_en,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted,
    output logic [IDX_W-1:0]             field_idx
);

    // Index value that denotes the command phase
    localparam logic [IDX_W-1:0] c_cmd_idx = IDX_W'(N_FIELDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIELD = 2'd1,
        S_CMD   = 2'd2
    } state_t;

    state_t                       state_q,     state_d;
    logic                         mode_q,      mode_d;
    logic [N_FIELDS*DATA_W-1:0]   data_q,      data_d;
    logic [DATA_W-1:0]            bus_out_q,   bus_out_d;
    logic                         wr_en_q,     wr_en_d;
    logic                         busy_q,      busy_d;
    logic                         done_q,      done_d;
    logic                         aborted_q,   aborted_d;
    logic [IDX_W-1:0]             field_idx_q, field_idx_d;

    logic [N_FIELDS-1:0]          w_mask_start;
    logic [N_FIELDS-1:0]          w_mask_run;
    logic [IDX_W-1:0]             w_first_idx;
    logic [IDX_W-1:0]             w_next_idx;
    logic [DATA_W-1:0]            w_cur_addr;
    logic [DATA_W-1:0]            w_cur_data;
    logic [DATA_W-1:0]            w_cmd_addr;

    // Field selection helpers: enabled masks, first/next enabled field, current field bytes
    always_comb begin
        w_mask_start = mode   ? '1 : TIMER_MASK;
        w_mask_run   = mode_q ? '1 : TIMER_MASK;
        w_cmd_addr   = mode_q ? CMD_ADDR_CLK : CMD_ADDR_TMR;
        w_first_idx  = c_cmd_idx;
        w_next_idx   = c_cmd_idx;
        w_cur_addr   = '0;
        w_cur_data   = '0;
        // Descending scan so the lowest qualifying field wins
        for (int i = N_FIELDS - 1; i >= 0; i--) begin
            if (w_mask_start[i]) begin
                w_first_idx = IDX_W'(i);
            end
            if (w_mask_run[i] && (IDX_W'(i) > field_idx_q)) begin
                w_next_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_FIELDS; i++) begin
            if (field_idx_q == IDX_W'(i)) begin
                w_cur_addr = addr_vec[i*DATA_W +: DATA_W];
                w_cur_data = data_q[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic; strobe priority abort > addr > data > advance
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        data_d      = data_q;
        bus_out_d   = bus_out_q;
        wr_en_d     = wr_en_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        field_idx_d = field_idx_q;

        case (state_q)
            S_IDLE: begin
                wr_en_d = 1'b0;
                busy_d  = 1'b0;
                if (start && !abort) begin
                    data_d      = data_vec;
                    mode_d      = mode;
                    busy_d      = 1'b1;
                    wr_en_d     = 1'b1;
                    field_idx_d = w_first_idx;
                    state_d     = (w_first_idx == c_cmd_idx) ? S_CMD : S_FIELD;
                end
            end
            S_FIELD, S_CMD: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    busy_d      = 1'b0;
                    wr_en_d     = 1'b0;
                    aborted_d   = 1'b1;
                    field_idx_d = '0;
                end else if (addr_phase) begin
                    bus_out_d = (state_q == S_CMD) ? w_cmd_addr : w_cur_addr;
                    wr_en_d   = 1'b1;
                end else if (data_phase) begin
                    bus_out_d = (state_q == S_CMD) ? CMD_DATA : w_cur_data;
                    wr_en_d   = 1'b1;
                end else if (advance) begin
                    // Write enable drops for the first cycle of the new item
                    wr_en_d = 1'b0;
                    if (state_q == S_CMD) begin
                        state_d     = S_IDLE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        field_idx_d = '0;
                    end else begin
                        field_idx_d = w_next_idx;
                        state_d     = (w_next_idx == c_cmd_idx) ? S_CMD : S_FIELD;
                    end
                end else begin
                    wr_en_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                busy_d      = 1'b0;
                wr_en_d     = 1'b0;
                field_idx_d = '0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            data_q      <= '0;
            bus_out_q   <= '0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            field_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            data_q      <= data_d;
            bus_out_q   <= bus_out_d;
            wr_en_q     <= wr_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            field_idx_q <= field_idx_d;
        end
    end

    assign bus_out   = bus_out_q;
    assign wr_en     = wr_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign field_idx = field_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_seq_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_seq_writer
// Brief    : Self-checking bench for rtc_seq_writer; directed scenarios plus
//            randomized strobes against an item-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_seq_writer;

    localparam int DW = 8;
    localparam int NF = 6;
    localparam int IW = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              start, mode, addr_phase, data_phase, advance, abort;
    logic [NF*DW-1:0]  addr_vec, data_vec;
    logic [DW-1:0]     bus_out;
    logic              wr_en, busy, done, aborted;
    logic [IW-1:0]     field_idx;

    rtc_seq_writer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .addr_vec   (addr_vec),
        .data_vec   (data_vec),
        .addr_phase (addr_phase),
        .data_phase (data_phase),
        .advance    (advance),
        .abort      (abort),
        .bus_out    (bus_out),
        .wr_en      (wr_en),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .field_idx  (field_idx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: list of items (enabled fields, then command NF)
    bit          m_busy, m_wr, m_done, m_abt, m_mode;
    logic [7:0]  m_bus;
    logic [7:0]  m_data [NF];
    int          items[$];
    int          pos;
    logic [5:0]  tmask = 6'b000111;

    int          done_cnt, abt_cnt;
    logic [7:0]  seen[$];

    function automatic logic [7:0] fld(input logic [NF*DW-1:0] v, input int i);
        return v[i*DW +: DW];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_wr = 0; m_done = 0; m_abt = 0; m_bus = 8'h00;
        items.delete(); pos = 0;
    endtask

    task automatic model_step();
        m_done = 0; m_abt = 0;
        if (!m_busy) begin
            m_wr = 0;
            if (start && !abort) begin
                m_mode = mode;
                for (int i = 0; i < NF; i++) m_data[i] = fld(data_vec, i);
                items.delete();
                for (int i = 0; i < NF; i++) if (mode || tmask[i]) items.push_back(i);
                items.push_back(NF);
                pos = 0; m_busy = 1; m_wr = 1;
            end
        end else if (abort) begin
            m_busy = 0; m_wr = 0; m_abt = 1;
        end else if (addr_phase) begin
            m_bus = (items[pos] == NF) ? (m_mode ? 8'hF1 : 8'hF2) : fld(addr_vec, items[pos]);
            m_wr = 1;
        end else if (data_phase) begin
            m_bus = (items[pos] == NF) ? 8'h01 : m_data[items[pos]];
            m_wr = 1;
        end else if (advance) begin
            pos++; m_wr = 0;
            if (pos == items.size()) begin m_busy = 0; m_done = 1; end
        end else begin
            m_wr = 1;
        end
    endtask

    task automatic check_outputs();
        chk("bus_out", 32'(bus_out), 32'(m_bus));
        chk("wr_en",   32'(wr_en),   32'(m_wr));
        chk("busy",    32'(busy),    32'(m_busy));
        chk("done",    32'(done),    32'(m_done));
        chk("aborted", 32'(aborted), 32'(m_abt));
        if (m_busy) chk("field_idx", 32'(field_idx), 32'(items[pos]));
        if (done === 1'b1)    done_cnt++;
        if (aborted === 1'b1) abt_cnt++;
    endtask

    task automatic cyc(input bit s, input bit ap, input bit dp, input bit adv, input bit ab);
        start = s; addr_phase = ap; data_phase = dp; advance = adv; abort = ab;
        model_step();
        @(posedge clk); #1;
        check_outputs();
        if (ap || dp) seen.push_back(bus_out);
        start = 0; addr_phase = 0; data_phase = 0; advance = 0; abort = 0;
    endtask

    task automatic do_item();
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
    endtask

    task automatic run_full(input bit md);
        mode = md;
        cyc(1, 0, 0, 0, 0);
        while (m_busy) do_item();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_bus"},  32'(bus_out),   0);
        chk({tag, "_wr"},   32'(wr_en),     0);
        chk({tag, "_busy"}, 32'(busy),      0);
        chk({tag, "_done"}, 32'(done),      0);
        chk({tag, "_abt"},  32'(aborted),   0);
        chk({tag, "_idx"},  32'(field_idx), 0);
    endtask

    logic [7:0] exp_clk [14];
    int d0;

    initial begin
        exp_clk = '{8'h21,8'h45,8'h22,8'h59,8'h23,8'h23,8'h24,8'h31,8'h25,8'h12,8'h26,8'h24,8'hF1,8'h01};
        reset = 1; start = 0; mode = 0; addr_phase = 0; data_phase = 0; advance = 0; abort = 0;
        addr_vec = {8'h26,8'h25,8'h24,8'h23,8'h22,8'h21};
        data_vec = {8'h24,8'h12,8'h31,8'h23,8'h59,8'h45};
        done_cnt = 0; abt_cnt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset = 0;

        // Clock mode, full sequence
        seen.delete();
        run_full(1);
        chk("clk_seen_len", seen.size(), 14);
        for (int i = 0; i < 14 && i < seen.size(); i++) chk("clk_seq", 32'(seen[i]), 32'(exp_clk[i]));
        chk("clk_done_cnt", done_cnt, 1);

        // Timer mode: fields 0..2 then command F2/01
        seen.delete();
        run_full(0);
        chk("tmr_seen_len", seen.size(), 8);
        if (seen.size() == 8) begin
            chk("tmr_cmd_addr", 32'(seen[6]), 32'h F2);
            chk("tmr_cmd_data", 32'(seen[7]), 32'h01);
        end
        chk("tmr_done_cnt", done_cnt, 2);

        // Snapshot: data_vec changed right after acceptance
        seen.delete();
        mode = 1;
        cyc(1, 0, 0, 0, 0);
        data_vec = {NF{8'hFF}};
        while (m_busy) do_item();
        if (seen.size() > 1) chk("snap_first_data", 32'(seen[1]), 32'h45);
        data_vec = {8'h24,8'h12,8'h31,8'h23,8'h59,8'h45};

        // Abort at field 3, then restart from field 0
        d0 = done_cnt;
        mode = 1;
        cyc(1, 0, 0, 0, 0);
        repeat (3) do_item();
        chk("abort_idx_before", 32'(field_idx), 3);
        cyc(0, 1, 0, 0, 1);
        chk("abort_pulse_cnt", abt_cnt, 1);
        cyc(0, 0, 0, 0, 0);
        chk("abort_no_done", done_cnt, d0);
        cyc(1, 0, 0, 0, 0);
        chk("restart_idx", 32'(field_idx), 0);

        // Both phases in one cycle, start mid-sequence ignored
        cyc(0, 1, 1, 0, 0);
        chk("both_phases_addr", 32'(bus_out), 32'h21);
        cyc(1, 0, 0, 0, 0);
        while (m_busy) do_item();

        // Reset during command phase
        mode = 0;
        cyc(1, 0, 0, 0, 0);
        repeat (3) do_item();
        cyc(0, 1, 0, 0, 0);
        chk("in_cmd_idx", 32'(field_idx), NF);
        reset = 1;
        #1;
        check_zero_outputs("async_rst");
        model_reset();
        @(posedge clk); #1;
        reset = 0;
        d0 = done_cnt;
        run_full(1);
        chk("post_rst_done", done_cnt, d0 + 1);

        // Randomized strobes
        for (int k = 0; k < 3000; k++) begin
            data_vec = {$urandom, $urandom};
            if (!m_busy) addr_vec = {$urandom, $urandom};
            mode = 1'($urandom);
            cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rtc_seq_writer.md
# rtc_seq_writer

Parametrised write sequencer for the RTC address/data bus. On a start request it snapshots a vector of time/date fields and walks through them one at a time, presenting each field's register address and then its value to the bus controller. It finishes with a transfer command. It sits between the main control FSM, which supplies the field values and the phase strobes, and the RTC bus driver, which consumes `bus_out` and `wr_en`. Compared with the fixed six-field writer it adds:
- configurable field count and width;
- a per-mode field mask;
- data snapshotting;
- abort;
- busy/index status.

## Interface
Parameters:
- `DATA_W`, 8, width of addresses, data and `bus_out`
- `N_FIELDS`, 6, number of fields; field 0 is written first
- `TIMER_MASK`, 6'b000111, fields written when `mode`=0; `mode`=1 writes all fields
- `CMD_ADDR_CLK`, 8'hF1, transfer-command address in clock mode
- `CMD_ADDR_TMR`, 8'hF2, transfer-command address in timer mode
- `CMD_DATA`, 8'h01, transfer-command data

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request a write sequence; sampled only in IDLE
- `mode`  in  1  1 = clock set, 0 = timer set; captured at start
- `addr_vec`  in  N_FIELDS*DATA_W  field i register address at [i*DATA_W +: DATA_W]; static
- `data_vec`  in  N_FIELDS*DATA_W  field i value, same packing; captured at start
- `addr_phase`  in  1  controller requests the address of the current item
- `data_phase`  in  1  controller requests the data of the current item
- `advance`  in  1  current item complete, move to the next
- `abort`  in  1  terminate the sequence immediately
- `bus_out`  out  DATA_W  registered address/data byte
- `wr_en`  out  1  write enable to the bus driver
- `busy`  out  1  high from start acceptance until return to IDLE
- `done`  out  1  single-cycle pulse: sequence completed
- `aborted`  out  1  single-cycle pulse: sequence aborted
- `field_idx`  out  clog2(N_FIELDS+1)  current item; N_FIELDS means command phase

## Operation
States: IDLE, FIELD, CMD.

**IDLE**
- On `start` (and no `abort`): capture `data_vec` and `mode`.
- Compute the enabled mask: all ones if `mode`=1, otherwise `TIMER_MASK`.
- Set `field_idx` to the lowest enabled field, go to FIELD and set `busy`.
- If no field is enabled, go directly to CMD with `field_idx`=N_FIELDS.

**FIELD and CMD** (priority per cycle: `abort` > `addr_phase` > `data_phase` > `advance`):
- `addr_phase`: `bus_out` <= addr_vec[field_idx] in FIELD; in CMD, `CMD_ADDR_CLK` if mode=1, else `CMD_ADDR_TMR`.
- `data_phase`: `bus_out` <= captured data[field_idx] in FIELD; `CMD_DATA` in CMD.
- `advance` in FIELD: `field_idx` jumps to the next enabled field above the current one. Skipped fields cost zero cycles. If none remains, go to CMD with `field_idx`=N_FIELDS.
- `advance` in CMD: go to IDLE and pulse `done`.
- `abort`: go to IDLE, pulse `aborted`, no `done`. `bus_out` holds its value.

**Other rules**
- `start` while busy is ignored.
- `start` and `abort` together in IDLE: abort dominates and start is ignored.
- `bus_out` holds its value when no phase strobe is present.
- Changes to `data_vec` after acceptance are not reflected in the sequence.

## Timing
- Reset values: state IDLE, `bus_out`=0, `wr_en`=0, `busy`=0, `done`=0, `aborted`=0, `field_idx`=0.
- All outputs are registered.
- `busy` and `wr_en` rise on the edge that accepts `start`.
- `wr_en`:
  - is 0 for exactly one cycle after each accepted `advance` (the cycle in the new item);
  - is 1 in all other busy cycles;
  - is 0 in IDLE.
- Phase strobes update `bus_out` one cycle after they are sampled.
- `done`/`aborted` are high in the first IDLE cycle only; `busy` is already 0 in that cycle.
- Minimum sequence length: (enabled fields + 1) advances.
- Reset mid-sequence: all outputs return to reset values asynchronously; no `done` or `aborted` pulse.

## Test plan
- Clock mode, default parameters, data_vec = {8'h24,8'h12,8'h31,8'h23,8'h59,8'h45}, addr_vec = 8'h21..8'h26. Issue addr/data/advance per item. Required: `bus_out` sequence 21,45,22,59,23,23,24,31,25,12,26,24,F1,01; one `done` pulse; `field_idx` 0..6.
- Timer mode, same vectors. Required: only fields 0–2 are written; after the third advance `field_idx`=6; command addr F2, data 01; `done` pulses.
- Modify `data_vec` to all 8'hFF one cycle after start. Required: the original snapshot values still appear on `bus_out`.
- Assert `abort` while at `field_idx`=3. Required: next cycle IDLE, `aborted`=1 for 1 cycle, `busy`=0, `done` never asserted; a subsequent `start` restarts at field 0.
- Assert `addr_phase` and `data_phase` in the same cycle. Required: address loaded. `start` pulsed mid-sequence. Required: no effect.
- Assert `reset` during CMD. Required: all outputs 0 immediately; next `start` runs a full sequence.
